// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked ripple-carry add/subtract, one register stage per chunk,
// with valid/ready flow control on both sides and carry/signed-overflow flags.
module pipelined_adder #(
  parameter int LENGTH = 16,
  parameter int STAGES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [LENGTH-1:0] a_i,
  input  logic [LENGTH-1:0] b_i,
  input  logic              sub_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [LENGTH-1:0] s_o,
  output logic              c_o,
  output logic              ovf_o
);
  localparam int W = LENGTH / STAGES;
  if (LENGTH < 1 || STAGES < 1 || STAGES > LENGTH || LENGTH % STAGES != 0) begin : g_bad
    $error("pipelined_adder: LENGTH must be a positive multiple of STAGES");
  end
  logic adv;
  assign adv     = !valid_o || ready_i;
  assign ready_o = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // operand bits still to be added on entry to this stage, current chunk in the low W bits
    localparam int R = LENGTH - k * W;
    logic [R-1:0]         a_in, b_in;
    logic                 cin, vin;
    logic [W:0]           sum;
    logic [(k+1)*W-1:0]   s_d, s_q;
    logic                 v_q, c_q;
    if (k == 0) begin : g_in
      assign a_in = a_i;
      assign b_in = sub_i ? ~b_i : b_i;
      assign cin  = sub_i;
      assign vin  = valid_i;
      assign s_d  = sum[W-1:0];
    end else begin : g_link
      assign a_in = g_st[k-1].g_op.a_q;
      assign b_in = g_st[k-1].g_op.b_q;
      assign cin  = g_st[k-1].c_q;
      assign vin  = g_st[k-1].v_q;
      assign s_d  = {sum[W-1:0], g_st[k-1].s_q};
    end
    assign sum = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, cin};
    // data registers only load real beats, so bubbles leave the last result on the outputs
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= vin;
        if (vin) begin
          c_q <= sum[W];
          s_q <= s_d;
        end
      end
    if (k < STAGES - 1) begin : g_op
      logic [R-W-1:0] a_q, b_q;
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && vin) begin
          a_q <= a_in[R-1:W];
          b_q <= b_in[R-1:W];
        end
    end else begin : g_msb
      logic cm_q;
      // carry into the MSB recovered from the MSB sum bit and its two operand bits
      always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cm_q <= 1'b0;
        else if (adv && vin) cm_q <= a_in[W-1] ^ b_in[W-1] ^ sum[W-1];
    end
  end
  assign valid_o = g_st[STAGES-1].v_q;
  assign s_o     = g_st[STAGES-1].s_q;
  assign c_o     = g_st[STAGES-1].c_q;
  assign ovf_o   = g_st[STAGES-1].c_q ^ g_st[STAGES-1].g_msb.cm_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of the 16/4 adder plus a latency/value sweep
// over other LENGTH/STAGES combinations.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic v_i, r_o, r_i, sub, v_o, c, ovf;
  logic [15:0] a, b, s;
  int tests = 0;
  int fails = 0;
  pipelined_adder #(.LENGTH(16), .STAGES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_i), .ready_o(r_o), .a_i(a), .b_i(b), .sub_i(sub),
    .valid_o(v_o), .ready_i(r_i), .s_o(s), .c_o(c), .ovf_o(ovf));
  logic        sw_v, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic [3:0]  sr, sv, sc, so;
  logic [15:0] s1, s16;
  logic [31:0] s32;
  logic [7:0]  s8;
  pipelined_adder #(.LENGTH(16), .STAGES(1)) u_16_1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(sw_v), .ready_o(sr[0]), .a_i(sw_a[15:0]), .b_i(sw_b[15:0]),
    .sub_i(sw_sub), .valid_o(sv[0]), .ready_i(1'b1), .s_o(s1), .c_o(sc[0]), .ovf_o(so[0]));
  pipelined_adder #(.LENGTH(16), .STAGES(16)) u_16_16 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(sw_v), .ready_o(sr[1]), .a_i(sw_a[15:0]), .b_i(sw_b[15:0]),
    .sub_i(sw_sub), .valid_o(sv[1]), .ready_i(1'b1), .s_o(s16), .c_o(sc[1]), .ovf_o(so[1]));
  pipelined_adder #(.LENGTH(32), .STAGES(8)) u_32_8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(sw_v), .ready_o(sr[2]), .a_i(sw_a), .b_i(sw_b),
    .sub_i(sw_sub), .valid_o(sv[2]), .ready_i(1'b1), .s_o(s32), .c_o(sc[2]), .ovf_o(so[2]));
  pipelined_adder #(.LENGTH(8), .STAGES(2)) u_8_2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(sw_v), .ready_o(sr[3]), .a_i(sw_a[7:0]), .b_i(sw_b[7:0]),
    .sub_i(sw_sub), .valid_o(sv[3]), .ready_i(1'b1), .s_o(s8), .c_o(sc[3]), .ovf_o(so[3]));

  logic [31:0] xa [6];
  logic [31:0] xb [6];
  logic        xs [6];

  // reference: {ovf, carry, sum} of an l-bit add/subtract
  function automatic logic [33:0] model(logic [31:0] x, logic [31:0] y, logic sb, int l);
    logic [63:0] m, xm, ym, f;
    m  = (64'd1 << l) - 64'd1;
    xm = {32'd0, x} & m;
    ym = (sb ? ~{32'd0, y} : {32'd0, y}) & m;
    f  = xm + ym + {63'd0, sb};
    return {(xm[l-1] == ym[l-1]) && (f[l-1] != xm[l-1]), f[l], f[31:0] & m[31:0]};
  endfunction

  function automatic logic [33:0] o16();
    return {ovf, c, 16'd0, s};
  endfunction

  task automatic check(string tag, logic [33:0] got, logic [33:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(logic v, logic [15:0] x, logic [15:0] y, logic sb);
    v_i = v; a = x; b = y; sub = sb;
    @(negedge clk);
  endtask

  task automatic chk_sw(string tag, int t, int st, int l, logic v, logic [33:0] got);
    int  k;
    logic ev;
    k  = t - st;
    ev = (k >= 0 && k < 6);
    check({tag, "_valid"}, {33'd0, v}, {33'd0, ev});
    if (ev) check(tag, got, model(xa[k], xb[k], xs[k], l));
  endtask

  initial begin
    logic [33:0] q [$];
    logic [33:0] held;
    int drawn, got, stall;
    logic acc, done;
    v_i = 0; a = 0; b = 0; sub = 0; r_i = 1;
    sw_v = 0; sw_a = 0; sw_b = 0; sw_sub = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", {33'd0, v_o}, 34'd0);
    check("rst_out", o16(), 34'd0);
    check("rst_ready", {33'd0, r_o}, 34'd1);
    rst_n = 1;
    @(negedge clk);
    check("rel_ready", {33'd0, r_o}, 34'd1);
    // basic add with latency check
    beat(1, 16'h0010, 16'h1011, 0);
    for (int i = 1; i < 4; i++) begin
      check("lat_gap", {33'd0, v_o}, 34'd0);
      beat(0, 0, 0, 0);
    end
    check("add_valid", {33'd0, v_o}, 34'd1);
    check("add", o16(), {2'b00, 32'h1021});
    // carry ripple, back to back
    beat(1, 16'hFFFF, 16'h0001, 0);
    beat(1, 16'hFFFF, 16'hFFFF, 0);
    beat(1, 16'h7FFF, 16'h0001, 0);
    beat(0, 0, 0, 0);
    check("rip0_valid", {33'd0, v_o}, 34'd1);
    check("rip0", o16(), {2'b01, 32'h0000});
    beat(0, 0, 0, 0);
    check("rip1_valid", {33'd0, v_o}, 34'd1);
    check("rip1", o16(), {2'b01, 32'hFFFE});
    beat(0, 0, 0, 0);
    check("rip2_valid", {33'd0, v_o}, 34'd1);
    check("rip2", o16(), {2'b10, 32'h8000});
    beat(0, 0, 0, 0);
    check("rip_end", {33'd0, v_o}, 34'd0);
    // subtract
    beat(1, 16'h0005, 16'h0007, 1);
    beat(1, 16'h8000, 16'h0001, 1);
    beat(1, 16'h1234, 16'h1234, 1);
    beat(0, 0, 0, 0);
    check("sub0", o16(), {2'b00, 32'hFFFE});
    beat(0, 0, 0, 0);
    check("sub1", o16(), {2'b11, 32'h7FFF});
    beat(0, 0, 0, 0);
    check("sub2_valid", {33'd0, v_o}, 34'd1);
    check("sub2", o16(), {2'b01, 32'h0000});
    beat(0, 0, 0, 0);
    // backpressure with scoreboard
    drawn = 0; got = 0; stall = 0; acc = 0; done = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (v_o && !done) begin
        stall = 3; done = 1; held = o16();
      end
      r_i = (stall == 0);
      if (!v_i || acc) begin
        if (drawn < 8) begin
          v_i = 1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); drawn++;
        end else v_i = 0;
      end
      #1;
      if (stall > 0) begin
        check("bp_ready", {33'd0, r_o}, 34'd0);
        if (stall < 3) check("bp_hold", {v_o, o16()}, {1'b1, held});
        stall--;
      end
      if (v_o && r_i) begin
        check("bp_nonempty", {33'd0, q.size() != 0}, 34'd1);
        if (q.size() != 0) check("bp_data", o16(), q.pop_front());
        got++;
      end
      acc = v_i && r_o;
      if (acc) q.push_back(model({16'd0, a}, {16'd0, b}, sub, 16));
      @(negedge clk);
    end
    check("bp_count", 34'(got), 34'd8);
    check("bp_stalled", {33'd0, done}, 34'd1);
    check("bp_drain", {33'd0, v_o}, 34'd0);
    v_i = 0; r_i = 1;
    @(negedge clk);
    // reset in flight
    beat(1, 16'h0001, 16'h0002, 0);
    beat(1, 16'h0003, 16'h0004, 0);
    beat(1, 16'h0005, 16'h0006, 1);
    beat(0, 0, 0, 0);
    check("pre_rst_valid", {33'd0, v_o}, 34'd1);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", {33'd0, v_o}, 34'd0);
    check("async_rst_out", o16(), 34'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", {33'd0, v_o}, 34'd0);
    end
    beat(1, 16'h0001, 16'h0001, 0);
    for (int i = 0; i < 3; i++) beat(0, 0, 0, 0);
    check("fresh_valid", {33'd0, v_o}, 34'd1);
    check("fresh", o16(), {2'b00, 32'h0002});
    beat(0, 0, 0, 0);
    // parameter sweep
    for (int j = 0; j < 6; j++) begin
      xa[j] = $urandom; xb[j] = $urandom; xs[j] = 1'($urandom);
    end
    xa[0] = 32'hFFFF_FFFF; xb[0] = 32'h0000_0001; xs[0] = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc < 6) begin
        sw_v = 1; sw_a = xa[cyc]; sw_b = xb[cyc]; sw_sub = xs[cyc];
      end else sw_v = 0;
      @(negedge clk);
      chk_sw("sw16_1", cyc + 1, 1, 16, sv[0], {so[0], sc[0], 16'd0, s1});
      chk_sw("sw16_16", cyc + 1, 16, 16, sv[1], {so[1], sc[1], 16'd0, s16});
      chk_sw("sw32_8", cyc + 1, 8, 32, sv[2], {so[2], sc[2], s32});
      chk_sw("sw8_2", cyc + 1, 2, 8, sv[3], {so[3], sc[3], 24'd0, s8});
    end
    check("sw_ready", {30'd0, sr}, 34'hF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the combinational ripple-carry adder. Operands of LENGTH bits are split into STAGES equal chunks. Each pipeline stage ripples one chunk and registers its carry into the next stage, so the clock period is set by one chunk instead of the full word. Adds a subtract mode, a signed-overflow flag and a valid/ready handshake on both sides, so the block can sit directly in a streaming datapath.

## Interface
- LENGTH, 16, operand and sum width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages (chunks); must be ≥ 1 and ≤ LENGTH, and LENGTH % STAGES must be 0, otherwise elaboration fails with $error.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- valid_i  input  1  operand beat present.
- ready_o  output  1  block accepts the beat this cycle.
- a_i  input  LENGTH  operand A.
- b_i  input  LENGTH  operand B.
- sub_i  input  1  0: A+B; 1: A−B (two's complement, B inverted, carry-in 1).
- valid_o  output  1  result beat present.
- ready_i  input  1  downstream accepts the result.
- s_o  output  LENGTH  sum/difference, modulo 2^LENGTH.
- c_o  output  1  carry out of the MSB; in subtract mode 1 means no borrow (A ≥ B unsigned).
- ovf_o  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Chunk width W = LENGTH/STAGES. Stage k (0..STAGES−1) adds bits [k·W +: W] of A and B′ (B′ = sub ? ~B : B) plus the carry registered by stage k−1. Stage 0 uses sub_i as its carry-in.
- Each stage register holds:
  - a valid bit;
  - the sum chunks computed so far;
  - the untouched upper chunks of A and B′;
  - the carry out of its chunk;
  - for the last stage only, the carry into the MSB.
- Global advance enable: adv = !valid_o || ready_i. Then ready_o = adv.
  - When adv = 1, every stage loads from its predecessor. Stage 0 loads valid_i, which means a beat is accepted exactly when valid_i && ready_o.
  - When adv = 0, all stages hold. Internal bubbles are not compressed.
- Outputs are driven directly from the last stage register: no combinational path from a_i/b_i/sub_i to s_o, c_o or ovf_o.
- The only combinational input-to-output path is ready_i → ready_o.
- Results leave in acceptance order. No beat is dropped or duplicated.
- STAGES = 1 degenerates to a single registered full-width ripple adder with the same handshake.

## Timing
- Reset (rst_ni low, any time, asynchronous):
  - valid_o = 0, s_o = 0, c_o = 0, ovf_o = 0.
  - All internal valid bits and carries are 0, and all in-flight beats are discarded.
  - ready_o = 1 while in reset and on the first cycle after release, because valid_o = 0.
- Latency: a beat accepted on the edge ending cycle t appears with valid_o = 1 in cycle t+STAGES, provided adv stayed 1 throughout.
- Throughput: one beat per cycle when ready_i = 1.
- Stall: while valid_o && !ready_i, the following hold stable: valid_o, s_o, c_o, ovf_o and all internal state. ready_o = 0 during the stall.
- Simultaneous accept and emit: with valid_o && ready_i && valid_i in the same cycle, the output beat retires and the new beat enters stage 0 on the same edge.
- Bubble output: when valid_o = 0, s_o, c_o and ovf_o are don't-care to the consumer. The implementation holds the last value.

## Test plan
All scenarios use LENGTH = 16, STAGES = 4, ready_i = 1 unless stated.
- Basic add: a = 0x0010, b = 0x1011, sub = 0, accepted at cycle 0 → valid_o at cycle 4 with s_o = 0x1021, c_o = 0, ovf_o = 0.
- Full carry ripple across all chunks:
  - 0xFFFF + 0x0001 → s_o = 0x0000, c = 1, ovf = 0.
  - 0xFFFF + 0xFFFF → s_o = 0xFFFE, c = 1, ovf = 0.
  - 0x7FFF + 0x0001 → s_o = 0x8000, c = 0, ovf = 1.
  - Issue these back-to-back; results must arrive on consecutive cycles 4, 5, 6.
- Subtract:
  - 0x0005 − 0x0007 → s_o = 0xFFFE, c = 0, ovf = 0.
  - 0x8000 − 0x0001 → s_o = 0x7FFF, c = 1, ovf = 1.
  - 0x1234 − 0x1234 → s_o = 0x0000, c = 1, ovf = 0.
- Backpressure: stream 8 random beats with valid_i = 1 and hold ready_i = 0 for 3 cycles once the first result appears.
  - ready_o = 0 during the stall.
  - Outputs stay stable during the stall.
  - All 8 results match the reference model (A ± B) in order, with no loss or duplication.
- Reset mid-operation: accept 3 beats, pull rst_ni low asynchronously between clock edges for 1 cycle, then release.
  - valid_o = 0 immediately and stays 0 for at least 4 cycles with no new input.
  - A fresh beat 0x0001 + 0x0001 then returns 0x0002 after 4 cycles.
- Parameter sweep: repeat the random stream for (LENGTH, STAGES) = (16,1), (16,16), (32,8) and (8,2), checking latency equals STAGES and every result against the model.
